// File: rtl/bp_pkg.sv
// Shared definitions for the branch predictor: counter states, default
// geometry and PC index/tag extraction.
package bp_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_t;

  localparam ctr_t        CTR_RESET     = WNT;
  localparam int unsigned BP_INDEX_BITS = 6;
  localparam int unsigned BP_TAG_BITS   = 8;

  function automatic logic [31:0] bp_index(input logic [31:0] pc,
                                           input int unsigned index_bits);
    return (pc >> 2) & ((32'd1 << index_bits) - 32'd1);
  endfunction

  function automatic logic [31:0] bp_tag(input logic [31:0] pc,
                                         input int unsigned index_bits,
                                         input int unsigned tag_bits);
    return (pc >> (index_bits + 2)) & ((32'd1 << tag_bits) - 32'd1);
  endfunction

  // Saturating 2-bit update toward the resolved outcome.
  function automatic ctr_t ctr_next(input ctr_t c, input logic taken);
    ctr_t n;
    n = c;
    if (taken && (c != ST))
      n = ctr_t'(c + 2'd1);
    else if (!taken && (c != SNT))
      n = ctr_t'(c - 2'd1);
    return n;
  endfunction

endpackage

// File: rtl/branch_history_table_if.sv
// Fetch-side prediction port and E/M-side training port of the branch predictor.
interface branch_history_table_if;

  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        pred_hit;

  logic        upd_en;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_mispredict;

  modport master (
    output if_pc, upd_en, upd_pc, upd_taken, upd_target, upd_mispredict,
    input  pred_taken, pred_target, pred_hit
  );

  modport slave (
    input  if_pc, upd_en, upd_pc, upd_taken, upd_target, upd_mispredict,
    output pred_taken, pred_target, pred_hit
  );

endinterface

// File: rtl/btb_array.sv
// Branch target buffer storage: tag/target/valid, one combinational read,
// one synchronous write, synchronous clear of the valid bits.
module btb_array #(
  parameter int unsigned INDEX_BITS = 6,
  parameter int unsigned TAG_BITS   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_BITS-1:0] rd_idx,
  input  logic [TAG_BITS-1:0]   rd_tag,
  output logic                  rd_hit,
  output logic [31:0]           rd_target,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_idx,
  input  logic [TAG_BITS-1:0]   wr_tag,
  input  logic [31:0]           wr_target
);

  localparam int unsigned ENTRIES = 32'd1 << INDEX_BITS;

  logic [ENTRIES-1:0] valid;
  logic [TAG_BITS-1:0] tag_mem [ENTRIES];
  logic [31:0]         tgt_mem [ENTRIES];

  always_ff @(posedge clk) begin
    if (rst)
      valid <= '0;
    else if (wr_en)
      valid[wr_idx] <= 1'b1;
  end

  // Tag/target need no reset: they are only observed through a valid bit.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      tag_mem[wr_idx] <= wr_tag;
      tgt_mem[wr_idx] <= wr_target;
    end
  end

  assign rd_hit    = valid[rd_idx] && (tag_mem[rd_idx] == rd_tag);
  assign rd_target = rd_hit ? tgt_mem[rd_idx] : '0;

endmodule

// File: rtl/branch_history_table.sv
// PC-indexed 2-bit saturating-counter branch predictor with branch statistics.
// Define BHT_BTB_EN to build the branch target buffer (tag-qualified prediction).
module branch_history_table
  import bp_pkg::*;
#(
  parameter int unsigned INDEX_BITS = BP_INDEX_BITS,
  parameter int unsigned TAG_BITS   = BP_TAG_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  branch_history_table_if.slave bus,
  output logic [31:0]           branch_cnt,
  output logic [31:0]           mispredict_cnt
);

  localparam int unsigned ENTRIES = 32'd1 << INDEX_BITS;

  ctr_t                  ctr [ENTRIES];
  logic [INDEX_BITS-1:0] rd_idx;
  logic [INDEX_BITS-1:0] wr_idx;
  ctr_t                  rd_ctr;
  logic                  ctr_taken;

  assign rd_idx    = INDEX_BITS'(bp_index(bus.if_pc, INDEX_BITS));
  assign wr_idx    = INDEX_BITS'(bp_index(bus.upd_pc, INDEX_BITS));
  assign rd_ctr    = ctr[rd_idx];
  assign ctr_taken = (rd_ctr == WT) || (rd_ctr == ST);

  // Reads see registered state only, so a same-cycle update is not bypassed.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++)
        ctr[i] <= CTR_RESET;
      branch_cnt     <= '0;
      mispredict_cnt <= '0;
    end else if (bus.upd_en) begin
      ctr[wr_idx] <= ctr_next(ctr[wr_idx], bus.upd_taken);
      branch_cnt  <= branch_cnt + 32'd1;
      if (bus.upd_mispredict)
        mispredict_cnt <= mispredict_cnt + 32'd1;
    end
  end

`ifdef BHT_BTB_EN
  logic [TAG_BITS-1:0] rd_tag;
  logic [TAG_BITS-1:0] wr_tag;
  logic                btb_hit;
  logic [31:0]         btb_target;

  assign rd_tag = TAG_BITS'(bp_tag(bus.if_pc, INDEX_BITS, TAG_BITS));
  assign wr_tag = TAG_BITS'(bp_tag(bus.upd_pc, INDEX_BITS, TAG_BITS));

  btb_array #(
    .INDEX_BITS(INDEX_BITS),
    .TAG_BITS  (TAG_BITS)
  ) u_btb (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (rd_idx),
    .rd_tag   (rd_tag),
    .rd_hit   (btb_hit),
    .rd_target(btb_target),
    .wr_en    (bus.upd_en && bus.upd_taken),
    .wr_idx   (wr_idx),
    .wr_tag   (wr_tag),
    .wr_target(bus.upd_target)
  );

  assign bus.pred_hit    = btb_hit;
  assign bus.pred_target = btb_target;
  assign bus.pred_taken  = ctr_taken && btb_hit;
`else
  logic [31:0] unused_upd_target;
  assign unused_upd_target = bus.upd_target;

  assign bus.pred_hit    = 1'b0;
  assign bus.pred_target = '0;
  assign bus.pred_taken  = ctr_taken;
`endif

endmodule

// File: tb/tb_branch_history_table.sv
// Scoreboard bench for branch_history_table: directed test-plan sequences plus
// random traffic, checked against an array-based predictor model.
module tb_branch_history_table;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] branch_cnt;
  logic [31:0] mispredict_cnt;

  branch_history_table_if bus();

  branch_history_table #(
    .INDEX_BITS(6),
    .TAG_BITS  (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .branch_cnt    (branch_cnt),
    .mispredict_cnt(mispredict_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        tk;
    logic        hit;
    logic [31:0] tgt;
    logic [31:0] b;
    logic [31:0] m;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: plain integer counters 0..3 and a direct-mapped target table.
  int unsigned m_ctr [64];
  bit          m_val [64];
  int unsigned m_tag [64];
  logic [31:0] m_tgt [64];
  logic [31:0] m_b;
  logic [31:0] m_m;

  function automatic int unsigned midx(input logic [31:0] pc);
    return (pc / 4) % 64;
  endfunction

  function automatic int unsigned mtag(input logic [31:0] pc);
    return (pc / 256) % 256;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      m_ctr[i] = 1;
      m_val[i] = 0;
    end
    m_b = 0;
    m_m = 0;
  endtask

  function automatic exp_t predict(input logic [31:0] pc);
    exp_t e;
    int unsigned i;
    i = midx(pc);
`ifdef BHT_BTB_EN
    e.hit = m_val[i] && (m_tag[i] == mtag(pc));
    e.tgt = e.hit ? m_tgt[i] : 32'd0;
    e.tk  = (m_ctr[i] >= 2) && e.hit;
`else
    e.hit = 1'b0;
    e.tgt = 32'd0;
    e.tk  = (m_ctr[i] >= 2);
`endif
    e.b = m_b;
    e.m = m_m;
    return e;
  endfunction

  task automatic step(input logic [31:0] pc, input bit en, input logic [31:0] upc,
                      input bit tk, input logic [31:0] tgt, input bit mp,
                      input bit r, input bit chk);
    int unsigned i;
    @(posedge clk);
    #1;
    bus.if_pc          = pc;
    bus.upd_en         = en;
    bus.upd_pc         = upc;
    bus.upd_taken      = tk;
    bus.upd_target     = tgt;
    bus.upd_mispredict = mp;
    rst                = r;
    if (chk) exp_q.push_back(predict(pc));
    if (r) begin
      model_reset();
    end else if (en) begin
      i = midx(upc);
      if (tk) begin
        if (m_ctr[i] < 3) m_ctr[i]++;
        m_val[i] = 1;
        m_tag[i] = mtag(upc);
        m_tgt[i] = tgt;
      end else if (m_ctr[i] > 0) begin
        m_ctr[i]--;
      end
      m_b = m_b + 1;
      if (mp) m_m = m_m + 1;
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, got, want);
    end
  endtask

  // Monitor: the predictor presents an answer every cycle; compare mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk32("pred_taken",     {31'd0, bus.pred_taken}, {31'd0, e.tk});
      chk32("pred_hit",       {31'd0, bus.pred_hit},   {31'd0, e.hit});
      chk32("pred_target",    bus.pred_target,         e.tgt);
      chk32("branch_cnt",     branch_cnt,              e.b);
      chk32("mispredict_cnt", mispredict_cnt,          e.m);
    end
  end

  initial begin
    logic [31:0] pc, upc, tgt;
    bus.if_pc = '0; bus.upd_en = 1'b0; bus.upd_pc = '0;
    bus.upd_taken = 1'b0; bus.upd_target = '0; bus.upd_mispredict = 1'b0;
    model_reset();

    // Reset; outputs are unknown until the first reset edge.
    step(32'h40, 0, 0, 0, 0, 0, 1, 0);
    step(32'h40, 0, 0, 0, 0, 0, 1, 1);
    step(32'h40, 0, 0, 0, 0, 0, 0, 1);

    // Train to strongly-taken while reading the same PC (no bypass).
    step(32'h40, 1, 32'h40, 1, 32'h20, 0, 0, 1);
    step(32'h40, 1, 32'h40, 1, 32'h20, 0, 0, 1);
    step(32'h40, 0, 0, 0, 0, 0, 0, 1);

    // Walk down through 10, 01, 00 and saturate.
    for (int k = 0; k < 4; k++)
      step(32'h40, 1, 32'h40, 0, 32'h20, 0, 0, 1);
    step(32'h40, 0, 0, 0, 0, 0, 0, 1);

    // Aliasing: same index, different tag.
    step(32'h40, 1, 32'h40, 1, 32'h20, 0, 0, 1);
    step(32'h40, 1, 32'h40, 1, 32'h20, 0, 0, 1);
    step(32'h1040, 0, 0, 0, 0, 0, 0, 1);
    step(32'h40, 0, 0, 0, 0, 0, 0, 1);

    // Stats, then a reset cycle with upd_en high.
    step(32'h40, 0, 0, 0, 0, 0, 1, 1);
    for (int k = 0; k < 5; k++)
      step(32'h40, 1, 32'h40, (k % 2 == 0), 32'h20, (k == 1 || k == 3), 0, 1);
    step(32'h40, 0, 0, 0, 0, 0, 0, 1);
    step(32'h40, 1, 32'h40, 1, 32'h20, 1, 1, 1);
    step(32'h40, 0, 0, 0, 0, 0, 0, 1);
    step(32'h40, 0, 0, 0, 0, 0, 0, 1);

    // Random traffic concentrated on a few indices/tags to force collisions.
    for (int k = 0; k < 600; k++) begin
      pc  = 32'h40 + ($urandom_range(0, 3) << 2) + ($urandom_range(0, 1) << 12);
      upc = 32'h40 + ($urandom_range(0, 3) << 2) + ($urandom_range(0, 1) << 12);
      if ($urandom_range(0, 7) == 0) pc = $urandom;
      if ($urandom_range(0, 7) == 0) upc = $urandom;
      tgt = $urandom & 32'hffff_fffc;
      step(pc, $urandom_range(0, 3) != 0, upc, $urandom_range(0, 1) == 1, tgt,
           $urandom_range(0, 3) == 0, $urandom_range(0, 63) == 0, 1);
    end
    step(32'h40, 0, 0, 0, 0, 0, 0, 0);

    // Drain the scoreboard with a bounded wait.
    for (int k = 0; k < 20 && exp_q.size() > 0; k++)
      @(negedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expected responses never checked, expected 0", exp_q.size());
    end
    @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_history_table.md
# branch_history_table

PC-indexed dynamic branch predictor for the 5-stage RV32 pipeline. It sits beside the fetch stage: it reads the fetch PC every cycle and supplies a taken/not-taken guess, and optionally a predicted target, to next-PC selection and to the F/D register's guess field. It is trained from the E/M stage with each resolved branch outcome. It also keeps branch and mispredict statistics counters.

## Interface
- `INDEX_BITS`, default 6: log2 of table entries (64); index = PC[INDEX_BITS+1:2]
- `TAG_BITS`, default 8: BTB tag width; tag = PC[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2]
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset, synchronous, active-high
- `if_pc`  in  32  current fetch PC from the PC register
- `pred_taken`  out  1  prediction for `if_pc`, combinational from table state
- `pred_target`  out  32  predicted target (BTB build only, else 0)
- `pred_hit`  out  1  BTB tag match for `if_pc` (BTB build only, else 0)
- `upd_en`  in  1  E/M-stage instruction is a conditional branch (E/M `is_branch`)
- `upd_pc`  in  32  E/M-stage PC
- `upd_taken`  in  1  E/M-stage resolved outcome
- `upd_target`  in  32  E/M-stage resolved target (jb_addr)
- `upd_mispredict`  in  1  E/M guess differed from outcome; sampled only with `upd_en`
- `branch_cnt`  out  32  resolved conditional branches since reset
- `mispredict_cnt`  out  32  mispredicted branches since reset

## Operation
- Each entry is a 2-bit saturating counter with these states: 00 strongly-not-taken, 01 weakly-not-taken, 10 weakly-taken, 11 strongly-taken.
- Read: `pred_taken` = counter[idx(if_pc)][1]. With the BTB build it is additionally ANDed with `pred_hit`.
- Update, on a clock edge with `upd_en`=1 and `rst`=0:
  - taken: counter +1, saturating at 11
  - not taken: counter -1, saturating at 00
- BTB update, when `upd_en` and `upd_taken` are both 1: write tag, target and valid=1 at idx(upd_pc). A not-taken branch never invalidates an entry.
- Stats: `branch_cnt` +1 per `upd_en`. `mispredict_cnt` +1 when `upd_en` and `upd_mispredict` are both 1. Both wrap modulo 2^32.
- The predictor ignores pipeline stalls and flushes. The E/M flush logic must deassert `upd_en` for bubbles.
- Aliasing is accepted: PCs with the same index share a counter.

## Timing
- Prediction has zero latency: it is combinational from registered state, in the same cycle as `if_pc`.
- An update takes effect at the next edge and is visible to reads from the following cycle.
- Read and update to the same index in the same cycle: the read returns the pre-update value. There is no bypass.
- Reset is synchronous. On the edge with `rst`=1:
  - all counters go to 01
  - all BTB valid bits clear
  - both stats counters go to 0
  - `upd_en` in that same cycle is ignored
- Output values after reset: `pred_taken`=0, `pred_hit`=0, `pred_target`=0, `branch_cnt`=0, `mispredict_cnt`=0.
- Reset asserted mid-run discards all trained state. There is no partial reset.

## Configuration
- `BHT_BTB_EN` defined:
  - tag/target/valid arrays are built
  - `pred_taken` = counter MSB AND tag hit
  - `pred_target` and `pred_hit` are driven from the BTB
- `BHT_BTB_EN` undefined:
  - no BTB storage
  - `pred_hit`=0, `pred_target`=0
  - `pred_taken` = counter MSB only; next-PC logic computes the target from the fetched instruction

## Structure
- Shared package `bp_pkg` holds:
  - 2-bit counter state constants (SNT/WNT/WT/ST)
  - reset state WNT
  - default INDEX_BITS/TAG_BITS
  - index/tag extraction helper functions
- One sub-module: `btb_array`. It holds tag/target/valid storage with one combinational read port, one synchronous write port and synchronous clear. It is instantiated only under `BHT_BTB_EN`.
- The counter array and stats counters live in the top module.

## Test plan
- Reset, then `if_pc`=0x0000_0040 -> `pred_taken`=0, `pred_hit`=0, both counters 0.
- Two taken updates at PC 0x40 (target 0x20) -> counter 11, `pred_taken`=1 for `if_pc`=0x40. With `BHT_BTB_EN`: `pred_target`=0x20.
- Counter at 11: one not-taken update -> still predicts taken (10). A second not-taken -> predicts not-taken (01). A third and fourth -> stays at 00 (saturation).
- Update at 0x40 and read of 0x40 in the same cycle -> old prediction that cycle, new prediction the next.
- Aliasing with BTB: train 0x40 taken, then read 0x1040 (same index, different tag) -> `pred_hit`=0, `pred_taken`=0. Without BTB -> `pred_taken`=1.
- 5 updates, 2 with `upd_mispredict`=1, then `rst` for one cycle with `upd_en`=1 -> stats read 5/2 before reset, 0/0 after, and counter at 0x40 back to 01.
